// File: rtl/apb_pkg.sv
// Shared APB definitions: FSM state encoding, default bus widths and the response status bundle.
// No logic and no latency; also consumed by apb_slave and future interconnect.
package apb_pkg;

    localparam int APB_ADDR_W = 32;
    localparam int APB_DATA_W = 32;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_ACCESS = 2'd2
    } apb_state_t;

    typedef struct packed {
        logic err;
        logic timeout;
    } apb_rsp_stat_t;

endpackage

// File: rtl/apb_master_if.sv
// APB3 single-slave bus bundle; master drives address/control/data, slave returns PRDATA/PREADY/PSLVERR.
// Pure wiring, zero latency; PREADY is the only backpressure on this bus.
interface apb_master_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic [ADDR_W-1:0] PADDR;
    logic              PWRITE;
    logic [DATA_W-1:0] PWDATA;
    logic              PSELx;
    logic              PENABLE;
    logic [DATA_W-1:0] PRDATA;
    logic              PREADY;
    logic              PSLVERR;

    modport master (
        output PADDR, PWRITE, PWDATA, PSELx, PENABLE,
        input  PRDATA, PREADY, PSLVERR
    );

    modport slave (
        input  PADDR, PWRITE, PWDATA, PSELx, PENABLE,
        output PRDATA, PREADY, PSLVERR
    );
endinterface

// File: rtl/apb_master.sv
// One-at-a-time APB3 requester: 3 cycles per zero-wait transfer, +1 per wait state, bounded by TIMEOUT.
// Commands are only taken in IDLE (o_cmd_ready); the response strobe has no backpressure.
module apb_master
    import apb_pkg::*;
#(
    parameter int ADDR_W  = APB_ADDR_W,
    parameter int DATA_W  = APB_DATA_W,
    parameter int TIMEOUT = 16
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic              i_cmd_valid,
    output logic              o_cmd_ready,
    input  logic [ADDR_W-1:0] i_cmd_addr,
    input  logic              i_cmd_write,
    input  logic [DATA_W-1:0] i_cmd_wdata,
    output logic              o_rsp_valid,
    output logic [DATA_W-1:0] o_rsp_rdata,
    output logic              o_rsp_err,
    output logic              o_rsp_timeout,
    apb_master_if.master      apb
);

    localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    apb_state_t        r_state;
    apb_state_t        w_next;
    logic [CNT_W-1:0]  r_cnt;
    logic [ADDR_W-1:0] r_paddr;
    logic              r_pwrite;
    logic [DATA_W-1:0] r_pwdata;
    logic              r_rsp_valid;
    logic [DATA_W-1:0] r_rsp_rdata;
    apb_rsp_stat_t     r_rsp_stat;
    logic              w_psel;
    logic              w_penable;
    logic              w_accept;
    logic              w_done;
    logic              w_expire;

    assign w_accept = i_cmd_valid && o_cmd_ready;
    assign w_done   = (r_state == ST_ACCESS) && apb.PREADY;
    // Abort in the TIMEOUT-th ACCESS cycle so ACCESS spans exactly TIMEOUT cycles.
    assign w_expire = (r_state == ST_ACCESS) && !apb.PREADY &&
                      (TIMEOUT != 0) && (r_cnt == CNT_LAST);

    always_ff @(posedge i_clk) begin
        if (i_reset) r_state <= ST_IDLE;
        else         r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE:   if (w_accept) w_next = ST_SETUP;
            ST_SETUP:  w_next = ST_ACCESS;
            ST_ACCESS: if (w_done || w_expire) w_next = ST_IDLE;
            default:   w_next = ST_IDLE;
        endcase
    end

    always_comb begin
        o_cmd_ready = (r_state == ST_IDLE);
        w_psel      = (r_state == ST_SETUP) || (r_state == ST_ACCESS);
        w_penable   = (r_state == ST_ACCESS);
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_cnt    <= '0;
            r_paddr  <= '0;
            r_pwrite <= 1'b0;
            r_pwdata <= '0;
        end else begin
            if (w_accept) begin
                r_cnt    <= '0;
                r_paddr  <= i_cmd_addr;
                r_pwrite <= i_cmd_write;
                r_pwdata <= i_cmd_wdata;
            end else if (r_state == ST_ACCESS && r_cnt != CNT_MAX) begin
                r_cnt <= r_cnt + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_rsp_valid <= 1'b0;
            r_rsp_rdata <= '0;
            r_rsp_stat  <= '0;
        end else begin
            r_rsp_valid <= w_done || w_expire;
            if (w_done) begin
                r_rsp_rdata        <= r_pwrite ? '0 : apb.PRDATA;
                r_rsp_stat.err     <= apb.PSLVERR;
                r_rsp_stat.timeout <= 1'b0;
            end else if (w_expire) begin
                r_rsp_rdata        <= '0;
                r_rsp_stat.err     <= 1'b1;
                r_rsp_stat.timeout <= 1'b1;
            end
        end
    end

    assign apb.PADDR    = r_paddr;
    assign apb.PWRITE   = r_pwrite;
    assign apb.PWDATA   = r_pwdata;
    assign apb.PSELx    = w_psel;
    assign apb.PENABLE  = w_penable;
    assign o_rsp_valid   = r_rsp_valid;
    assign o_rsp_rdata   = r_rsp_rdata;
    assign o_rsp_err     = r_rsp_stat.err;
    assign o_rsp_timeout = r_rsp_stat.timeout;

endmodule

// File: tb/tb_apb_master.sv
// Directed bench for apb_master (TIMEOUT=4) against a small behavioural APB slave with programmable wait states.
module tb_apb_master;

    logic        clk = 1'b0;
    logic        rst;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [31:0] cmd_addr;
    logic        cmd_write;
    logic [31:0] cmd_wdata;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic        rsp_timeout;

    int n_vec = 0;
    int n_err = 0;

    apb_master_if #(.ADDR_W(32), .DATA_W(32)) bus ();

    apb_master #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(4)) dut (
        .i_clk         (clk),
        .i_reset       (rst),
        .i_cmd_valid   (cmd_valid),
        .o_cmd_ready   (cmd_ready),
        .i_cmd_addr    (cmd_addr),
        .i_cmd_write   (cmd_write),
        .i_cmd_wdata   (cmd_wdata),
        .o_rsp_valid   (rsp_valid),
        .o_rsp_rdata   (rsp_rdata),
        .o_rsp_err     (rsp_err),
        .o_rsp_timeout (rsp_timeout),
        .apb           (bus)
    );

    always #5 clk = ~clk;

    // Slave model: wait_cfg low-PREADY ACCESS cycles before ready; negative means never ready.
    int          wait_cfg = 0;
    int          acc_cnt  = 0;
    logic [31:0] mem [0:31];

    always @(posedge clk) begin
        if (bus.PSELx && bus.PENABLE) begin
            if (bus.PREADY) begin
                if (bus.PWRITE && !bus.PSLVERR) mem[bus.PADDR[4:0]] <= bus.PWDATA;
                acc_cnt <= 0;
            end else begin
                acc_cnt <= acc_cnt + 1;
            end
        end else begin
            acc_cnt <= 0;
        end
    end

    always_comb begin
        bus.PREADY  = (wait_cfg < 0) ? 1'b0 : (acc_cnt >= wait_cfg);
        bus.PSLVERR = (bus.PADDR == 32'hFFFF_FFFF);
        bus.PRDATA  = (bus.PADDR == 32'hFFFF_FFFF) ? 32'hBADB_AD00 : mem[bus.PADDR[4:0]];
    end

    int acc_count = 0;
    always @(posedge clk) begin
        if (!rst && cmd_valid && cmd_ready) acc_count <= acc_count + 1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Issue one command from a negedge; returns at the negedge of the response cycle k+lat.
    task automatic run_cmd(input logic [31:0] a, input logic w, input logic [31:0] d,
                           input int waits, output int lat, output int acc_cycles);
        logic stable_ok;
        wait_cfg  = waits;
        cmd_addr  = a;
        cmd_write = w;
        cmd_wdata = d;
        cmd_valid = 1'b1;
        check("ready_before_accept", {31'b0, cmd_ready}, 32'd1);
        @(posedge clk);
        #1 cmd_valid = 1'b0;
        lat        = 0;
        acc_cycles = 0;
        stable_ok  = 1'b1;
        for (int c = 1; c <= 20; c++) begin
            @(negedge clk);
            if (rsp_valid) begin
                lat = c;
                break;
            end
            if (c == 1) begin
                check("setup_psel", {31'b0, bus.PSELx}, 32'd1);
                check("setup_penable", {31'b0, bus.PENABLE}, 32'd0);
            end else if (bus.PSELx && bus.PENABLE) begin
                acc_cycles++;
            end else begin
                stable_ok = 1'b0;
            end
            if (bus.PADDR !== a || bus.PWRITE !== w || bus.PWDATA !== d) stable_ok = 1'b0;
        end
        check("bus_stable", {31'b0, stable_ok}, 32'd1);
    endtask

    initial begin
        int lat;
        int accs;
        int acc_before;
        logic saw_rsp;

        rst       = 1'b1;
        cmd_valid = 1'b0;
        cmd_addr  = '0;
        cmd_write = 1'b0;
        cmd_wdata = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_psel", {31'b0, bus.PSELx}, 32'd0);
        check("rst_penable", {31'b0, bus.PENABLE}, 32'd0);
        check("rst_ready", {31'b0, cmd_ready}, 32'd1);
        check("rst_rsp_valid", {31'b0, rsp_valid}, 32'd0);
        check("rst_rsp_rdata", rsp_rdata, 32'd0);
        check("rst_rsp_err", {31'b0, rsp_err}, 32'd0);
        check("rst_rsp_timeout", {31'b0, rsp_timeout}, 32'd0);
        check("rst_paddr", bus.PADDR, 32'd0);
        rst = 1'b0;

        // Zero-wait write
        run_cmd(32'h1, 1'b1, 32'hDEAD_BEEF, 0, lat, accs);
        check("wr0_latency", lat, 32'd3);
        check("wr0_err", {31'b0, rsp_err}, 32'd0);
        check("wr0_rdata", rsp_rdata, 32'd0);
        check("wr0_mem", mem[1], 32'hDEAD_BEEF);

        // Back-to-back from the response cycle: write then read 0x10
        run_cmd(32'h10, 1'b1, 32'hDEAD_BEEF, 0, lat, accs);
        check("wr10_latency", lat, 32'd3);
        run_cmd(32'h10, 1'b0, 32'h0, 0, lat, accs);
        check("rd10_latency", lat, 32'd3);
        check("rd10_rdata", rsp_rdata, 32'hDEAD_BEEF);
        check("rd10_err", {31'b0, rsp_err}, 32'd0);

        // Three wait states
        run_cmd(32'h5, 1'b1, 32'h1234_5678, 3, lat, accs);
        check("ws_latency", lat, 32'd6);
        check("ws_access_cycles", accs, 32'd4);
        check("ws_timeout", {31'b0, rsp_timeout}, 32'd0);
        check("ws_mem", mem[5], 32'h1234_5678);
        run_cmd(32'h5, 1'b0, 32'hA5A5_A5A5, 2, lat, accs);
        check("ws_rd_latency", lat, 32'd5);
        check("ws_rd_rdata", rsp_rdata, 32'h1234_5678);

        // Slave error
        run_cmd(32'hFFFF_FFFF, 1'b0, 32'h0, 0, lat, accs);
        check("err_latency", lat, 32'd3);
        check("err_err", {31'b0, rsp_err}, 32'd1);
        check("err_timeout", {31'b0, rsp_timeout}, 32'd0);
        check("err_rdata", rsp_rdata, 32'hBADB_AD00);

        // Timeout with PREADY stuck low
        run_cmd(32'h2, 1'b0, 32'h0, -1, lat, accs);
        check("to_latency", lat, 32'd6);
        check("to_access_cycles", accs, 32'd4);
        check("to_err", {31'b0, rsp_err}, 32'd1);
        check("to_timeout", {31'b0, rsp_timeout}, 32'd1);
        check("to_rdata", rsp_rdata, 32'd0);
        @(negedge clk);
        check("hold_valid_pulse", {31'b0, rsp_valid}, 32'd0);
        check("hold_err", {31'b0, rsp_err}, 32'd1);
        check("hold_timeout", {31'b0, rsp_timeout}, 32'd1);

        // Reset during ACCESS with i_cmd_valid held high throughout
        wait_cfg   = -1;
        acc_before = acc_count;
        cmd_addr   = 32'h3;
        cmd_write  = 1'b1;
        cmd_wdata  = 32'h0BAD_F00D;
        cmd_valid  = 1'b1;
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        check("mid_in_access", {30'b0, bus.PSELx, bus.PENABLE}, 32'd3);
        rst = 1'b1;
        @(negedge clk);
        check("mid_psel", {31'b0, bus.PSELx}, 32'd0);
        check("mid_penable", {31'b0, bus.PENABLE}, 32'd0);
        check("mid_ready", {31'b0, cmd_ready}, 32'd1);
        check("mid_accepts", acc_count - acc_before, 32'd1);
        rst       = 1'b0;
        cmd_valid = 1'b0;
        saw_rsp   = 1'b0;
        for (int i = 0; i < 6; i++) begin
            if (rsp_valid) saw_rsp = 1'b1;
            @(negedge clk);
        end
        check("mid_no_rsp", {31'b0, saw_rsp}, 32'd0);
        check("mid_idle_ready", {31'b0, cmd_ready}, 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/apb_master.md
# apb_master

Single-slave APB3 requester that sits directly upstream of `apb_slave`. It accepts one command at a time on a valid/ready request port and sequences the APB SETUP and ACCESS phases. It waits for PREADY, bounded by a configurable timeout, and returns read data and error status on a one-cycle response strobe. It is the bridge between internal control logic (CPU shim, test sequencer) and the slave's PADDR/PWRITE/PWDATA/PSELx/PENABLE bus.

## Interface
- `ADDR_W`, default 32: PADDR width.
- `DATA_W`, default 32: PWDATA/PRDATA width.
- `TIMEOUT`, default 16: maximum ACCESS cycles waited for PREADY. A value of 0 disables the timeout.

- `i_clk`  in  1  sole clock; all state updates on its rising edge.
- `i_reset`  in  1  synchronous, active-high reset.
- `i_cmd_valid`  in  1  command request.
- `o_cmd_ready`  out  1  high only in IDLE; a command is accepted on the edge where valid && ready.
- `i_cmd_addr`  in  ADDR_W  transfer address.
- `i_cmd_write`  in  1  1 = write, 0 = read.
- `i_cmd_wdata`  in  DATA_W  write data; ignored for reads.
- `o_rsp_valid`  out  1  one-cycle completion strobe; no backpressure.
- `o_rsp_rdata`  out  DATA_W  PRDATA captured on completion for reads; 0 for writes and timeouts.
- `o_rsp_err`  out  1  PSLVERR captured on completion, or 1 on timeout.
- `o_rsp_timeout`  out  1  set when the transfer was aborted by the timeout.
- `PADDR`  out  ADDR_W.
- `PWRITE`  out  1.
- `PWDATA`  out  DATA_W.
- `PSELx`  out  1.
- `PENABLE`  out  1.
- `PRDATA`  in  DATA_W.
- `PREADY`  in  1.
- `PSLVERR`  in  1.

## Operation
- **FSM states:** IDLE, SETUP, ACCESS.
- **IDLE**
  - PSELx=0, PENABLE=0, o_cmd_ready=1.
  - On accept: register addr/write/wdata onto PADDR/PWRITE/PWDATA and go to SETUP.
- **SETUP**
  - PSELx=1, PENABLE=0.
  - Unconditionally go to ACCESS.
- **ACCESS**
  - PSELx=1, PENABLE=1; the timeout counter increments each cycle.
  - **PREADY=1:** capture PRDATA (reads only) and PSLVERR into the response registers. Pulse o_rsp_valid next cycle. Return to IDLE.
  - **PREADY=0 and the counter has reached TIMEOUT (TIMEOUT≠0):** abort and return to IDLE. Response is err=1, timeout=1, rdata=0.
- **Bus signal rules**
  - PADDR/PWRITE/PWDATA stay stable from SETUP through the end of ACCESS.
  - In IDLE they hold their last value.
  - PSLVERR and PRDATA are sampled only when PSELx && PENABLE && PREADY.
- **Reset**
  - Every output resets to 0, with one exception: o_cmd_ready=1 after reset, because reset enters IDLE.
  - The state resets to IDLE and the counter to 0.
- **Reset mid-transfer:** the next edge forces IDLE with PSELx=PENABLE=0. No response is emitted and the command is dropped.
- **Busy:** while not IDLE, i_cmd_valid is ignored (not accepted, not queued).
- **Counter:** width $clog2(TIMEOUT+1). It clears on entry to SETUP and saturates at TIMEOUT.

## Timing
- Accept on edge k:
  - SETUP occupies cycle k+1.
  - ACCESS begins at cycle k+2.
- Zero-wait slave:
  - Completion is at the edge ending cycle k+2.
  - o_rsp_valid=1 and o_cmd_ready=1 during cycle k+3.
  - Throughput is one transfer per 3 cycles.
- N wait states: o_rsp_valid is asserted in cycle k+3+N.
- Timeout with TIMEOUT=T and PREADY held low:
  - ACCESS lasts T cycles.
  - o_rsp_valid with timeout=1 is asserted in cycle k+2+T.
- o_rsp_* values hold until the next completion. Only o_rsp_valid is a pulse.
- Command accepted in the same cycle that o_rsp_valid is high: legal, handled normally.

## Structure
- Shared package `apb_pkg` contains:
  - the state encoding (IDLE/SETUP/ACCESS);
  - default ADDR_W/DATA_W constants;
  - a response-field bundle definition, shared with the slave and future interconnect.
- No sub-module. The FSM, the bus registers and the timeout counter stay in one file.

## Test plan
- **Zero-wait write:** write 0xDEADBEEF to 0x1 against apb_slave.
  - PSELx rises in k+1 and PENABLE in k+2.
  - o_rsp_valid in k+3 with err=0.
  - slave.reg_file_1 == 0xDEADBEEF.
- **Zero-wait read:** read 0x10 after a write of 0xDEADBEEF to 0x10.
  - o_rsp_rdata == 0xDEADBEEF, err=0.
- **Wait states:** model slave holds PREADY low for 3 ACCESS cycles.
  - PADDR/PWDATA stable throughout.
  - o_rsp_valid in k+6.
- **Slave error:** address 0xFFFF_FFFF with PSLVERR=1 on completion.
  - o_rsp_err=1, o_rsp_timeout=0.
- **Timeout:** TIMEOUT=4 with PREADY stuck low.
  - PSELx drops after 4 ACCESS cycles.
  - o_rsp_valid in k+6 with err=1, timeout=1, rdata=0.
- **Reset mid-ACCESS:** i_reset pulsed during ACCESS.
  - Next cycle: PSELx=PENABLE=0 and o_cmd_ready=1.
  - No o_rsp_valid.
  - i_cmd_valid held high while busy yields exactly one accepted command.
